// File: rtl/multi_deque.sv
// multi_deque: CHANNELS independent double-ended queues sharing one command port.
// Each deque is a circular buffer with head (front word), tail (next free slot
// after the back word) and an occupancy counter. Only the deque addressed by
// sel can change in a cycle. The peek, count, empty and full outputs are
// decoded combinationally from the registered state.
module multi_deque #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(CHANNELS)-1:0]   sel,
    input  logic                          end_select,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          clear,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [$clog2(DEPTH):0]        count,
    output logic [CHANNELS-1:0]           empty,
    output logic [CHANNELS-1:0]           full,
    output logic [CHANNELS-1:0]           overflow,
    output logic [CHANNELS-1:0]           underflow
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage and per-deque bookkeeping
    logic [WIDTH-1:0] mem_r   [CHANNELS][DEPTH];
    logic [PTR_W-1:0] head_r  [CHANNELS];
    logic [PTR_W-1:0] tail_r  [CHANNELS];
    logic [CNT_W-1:0] count_r [CHANNELS];
    logic [CHANNELS-1:0] ovf_r;
    logic [CHANNELS-1:0] udf_r;

    // Decoded view of the addressed deque
    logic             sel_ok_s;
    logic [SEL_W-1:0] sel_idx_s;
    logic [PTR_W-1:0] cur_head_s;
    logic [PTR_W-1:0] cur_tail_s;
    logic [PTR_W-1:0] back_idx_s;
    logic [CNT_W-1:0] cur_count_s;
    logic             cur_empty_s;
    logic             cur_full_s;
    logic [WIDTH-1:0] peek_s;
    logic [CHANNELS-1:0] hit_s;

    // Next state for the addressed deque
    logic [PTR_W-1:0] nxt_head_s;
    logic [PTR_W-1:0] nxt_tail_s;
    logic [CNT_W-1:0] nxt_count_s;
    logic             set_ovf_s;
    logic             set_udf_s;
    logic             do_clr_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_addr_s;

    // Address decode and peek of the selected end of the selected deque
    always_comb begin
        sel_ok_s    = (32'(sel) < 32'(CHANNELS));
        sel_idx_s   = sel_ok_s ? sel : {SEL_W{1'b0}};
        cur_head_s  = head_r[sel_idx_s];
        cur_tail_s  = tail_r[sel_idx_s];
        cur_count_s = count_r[sel_idx_s];
        back_idx_s  = cur_tail_s - {{(PTR_W-1){1'b0}}, 1'b1};
        cur_empty_s = (cur_count_s == {CNT_W{1'b0}});
        cur_full_s  = (cur_count_s == CNT_W'(DEPTH));
        if (end_select) begin
            peek_s = mem_r[sel_idx_s][back_idx_s];
        end else begin
            peek_s = mem_r[sel_idx_s][cur_head_s];
        end
        if (sel_ok_s && !cur_empty_s) begin
            data_out = peek_s;
        end else begin
            data_out = {WIDTH{1'b0}};
        end
        if (sel_ok_s) begin
            count = cur_count_s;
        end else begin
            count = {CNT_W{1'b0}};
        end
    end

    // One-hot of the deque allowed to change this cycle
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hit_s[i] = sel_ok_s && (sel_idx_s == SEL_W'(i));
        end
    end

    // Command decode: clear beats push/pop; push+pop on a non-empty deque overwrites
    always_comb begin
        nxt_head_s  = cur_head_s;
        nxt_tail_s  = cur_tail_s;
        nxt_count_s = cur_count_s;
        set_ovf_s   = 1'b0;
        set_udf_s   = 1'b0;
        do_clr_s    = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = cur_head_s;
        if (!sel_ok_s) begin
            do_clr_s = 1'b0;
        end else if (clear) begin
            do_clr_s = 1'b1;
        end else if (push && pop && !cur_empty_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = end_select ? back_idx_s : cur_head_s;
        end else if (push) begin
            if (cur_full_s) begin
                set_ovf_s = 1'b1;
            end else if (end_select) begin
                wr_en_s     = 1'b1;
                wr_addr_s   = cur_tail_s;
                nxt_tail_s  = cur_tail_s + {{(PTR_W-1){1'b0}}, 1'b1};
                nxt_count_s = cur_count_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                wr_en_s     = 1'b1;
                wr_addr_s   = cur_head_s - {{(PTR_W-1){1'b0}}, 1'b1};
                nxt_head_s  = cur_head_s - {{(PTR_W-1){1'b0}}, 1'b1};
                nxt_count_s = cur_count_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (pop) begin
            if (cur_empty_s) begin
                set_udf_s = 1'b1;
            end else if (end_select) begin
                nxt_tail_s  = back_idx_s;
                nxt_count_s = cur_count_s - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                nxt_head_s  = cur_head_s + {{(PTR_W-1){1'b0}}, 1'b1};
                nxt_count_s = cur_count_s - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            do_clr_s = 1'b0;
        end
    end

    // Pointer, count and sticky-flag registers; reset empties every deque at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                head_r[i]  <= {PTR_W{1'b0}};
                tail_r[i]  <= {PTR_W{1'b0}};
                count_r[i] <= {CNT_W{1'b0}};
            end
            ovf_r <= {CHANNELS{1'b0}};
            udf_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit_s[i]) begin
                    if (do_clr_s) begin
                        head_r[i]  <= {PTR_W{1'b0}};
                        tail_r[i]  <= {PTR_W{1'b0}};
                        count_r[i] <= {CNT_W{1'b0}};
                        ovf_r[i]   <= 1'b0;
                        udf_r[i]   <= 1'b0;
                    end else begin
                        head_r[i]  <= nxt_head_s;
                        tail_r[i]  <= nxt_tail_s;
                        count_r[i] <= nxt_count_s;
                        ovf_r[i]   <= ovf_r[i] | set_ovf_s;
                        udf_r[i]   <= udf_r[i] | set_udf_s;
                    end
                end
            end
        end
    end

    // Word storage; contents are never reset, only the bookkeeping is
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[sel_idx_s][wr_addr_s] <= data_in;
        end
    end

    // Per-deque status flags decoded from the count registers
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i] = (count_r[i] == {CNT_W{1'b0}});
            full[i]  = (count_r[i] == CNT_W'(DEPTH));
        end
    end

    assign overflow  = ovf_r;
    assign underflow = udf_r;

endmodule

// File: tb/tb_multi_deque.sv
// Bench for multi_deque (default parameters). Stimulus issues commands and
// queues the expected value of one DUT output per check cycle; a monitor on
// the falling edge pops each expectation and compares it with the DUT.
module tb_multi_deque;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic       end_select;
    logic       push;
    logic       pop;
    logic       clear;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [3:0] count;
    logic [3:0] empty;
    logic [3:0] full;
    logic [3:0] overflow;
    logic [3:0] underflow;

    typedef enum int {K_DATA, K_COUNT, K_EMPTY, K_FULL, K_OVF, K_UDF} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    multi_deque #(.WIDTH(8), .CHANNELS(4), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .end_select (end_select),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .data_in    (data_in),
        .data_out   (data_out),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the live outputs
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_DATA:  act = 32'(data_out);
                K_COUNT: act = 32'(count);
                K_EMPTY: act = 32'(empty);
                K_FULL:  act = 32'(full);
                K_OVF:   act = 32'(overflow);
                K_UDF:   act = 32'(underflow);
                default: act = 32'hDEAD_BEEF;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic cmd(input int ch, input bit e, input bit pu, input bit po,
                       input bit cl, input logic [7:0] d);
        sel        = 2'(ch);
        end_select = e;
        push       = pu;
        pop        = po;
        clear      = cl;
        data_in    = d;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic chk(input int ch, input bit e, input kind_t k,
                       input logic [31:0] v, input string nm);
        exp_t x;
        sel        = 2'(ch);
        end_select = e;
        x.kind = k;
        x.exp  = v;
        x.name = nm;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 2'd0; end_select = 1'b0;
        push = 1'b0; pop = 1'b0; clear = 1'b0; data_in = 8'h00;
        @(posedge clk);
        #1;
        // Reset state
        chk(0, 1'b0, K_EMPTY, 32'h0000_000F, "rst_empty");
        chk(0, 1'b0, K_FULL,  32'h0000_0000, "rst_full");
        chk(0, 1'b0, K_OVF,   32'h0000_0000, "rst_ovf");
        chk(0, 1'b0, K_UDF,   32'h0000_0000, "rst_udf");
        chk(0, 1'b0, K_DATA,  32'h0000_0000, "rst_data");
        chk(0, 1'b0, K_COUNT, 32'h0000_0000, "rst_count");
        rst_n = 1'b1;

        // Push back 11,22,33 to ch0
        cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        chk(0, 1'b0, K_COUNT, 32'd3,   "ch0_count3");
        chk(0, 1'b0, K_DATA,  32'h11,  "ch0_front");
        chk(0, 1'b1, K_DATA,  32'h33,  "ch0_back");
        chk(0, 1'b0, K_EMPTY, 32'hE,   "ch0_nonempty");

        // Interleave ch1 and ch0
        cmd(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h51);
        cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
        cmd(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h52);
        chk(0, 1'b0, K_COUNT, 32'd4,  "il_ch0_count");
        chk(0, 1'b1, K_DATA,  32'h44, "il_ch0_back");
        chk(1, 1'b0, K_COUNT, 32'd2,  "il_ch1_count");
        chk(1, 1'b0, K_DATA,  32'h51, "il_ch1_front");
        chk(1, 1'b1, K_DATA,  32'h52, "il_ch1_back");
        chk(2, 1'b0, K_EMPTY, 32'hC,  "il_empty");

        // Underflow on ch1, then clear
        cmd(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk(1, 1'b0, K_COUNT, 32'd0,  "clr_ch1_count");
        cmd(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk(1, 1'b0, K_UDF,   32'h2,  "udf_ch1_set");
        chk(1, 1'b0, K_COUNT, 32'd0,  "udf_ch1_count");
        chk(1, 1'b0, K_DATA,  32'h0,  "udf_ch1_data");
        cmd(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk(1, 1'b0, K_UDF,   32'h0,  "udf_ch1_clr");

        // Push front A1..A8 to ch2, then overflow
        for (int i = 0; i < 8; i++) cmd(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
        chk(2, 1'b0, K_FULL,  32'h4,  "ch2_full");
        chk(2, 1'b0, K_COUNT, 32'd8,  "ch2_count8");
        chk(2, 1'b0, K_DATA,  32'hA8, "ch2_front");
        cmd(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk(2, 1'b0, K_OVF,   32'h4,  "ch2_ovf");
        chk(2, 1'b0, K_COUNT, 32'd8,  "ch2_ovf_count");
        chk(2, 1'b0, K_DATA,  32'hA8, "ch2_ovf_front");
        for (int i = 0; i < 8; i++) begin
            chk(2, 1'b1, K_DATA, 32'(8'hA1 + 8'(i)), "ch2_popback");
            cmd(2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk(2, 1'b1, K_COUNT, 32'd0,  "ch2_drained");
        chk(2, 1'b1, K_DATA,  32'h0,  "ch2_empty_data");
        chk(2, 1'b0, K_OVF,   32'h4,  "ch2_ovf_sticky");

        // Push+pop on empty acts as push; no underflow
        cmd(2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        chk(2, 1'b0, K_COUNT, 32'd1,  "pp_empty_count");
        chk(2, 1'b0, K_DATA,  32'h77, "pp_empty_front");
        chk(2, 1'b0, K_UDF,   32'h0,  "pp_empty_udf");

        // Clear, then alternate front/back pushes from a non-zero pointer
        cmd(2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk(2, 1'b0, K_OVF,   32'h0,  "ch2_clr_ovf");
        chk(2, 1'b0, K_COUNT, 32'd0,  "ch2_clr_count");
        cmd(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC0);
        cmd(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC1);
        cmd(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cmd(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cmd(2, (i % 2) == 1, 1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
        chk(2, 1'b0, K_FULL,  32'h4,  "wrap_full");
        chk(2, 1'b0, K_DATA,  32'hB6, "wrap_front");
        chk(2, 1'b1, K_DATA,  32'hB7, "wrap_back");
        cmd(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk(2, 1'b0, K_DATA,  32'hB4, "wrap_popfront");

        // ch3: push+pop back overwrites
        cmd(3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
        cmd(3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h06);
        cmd(3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
        chk(3, 1'b0, K_COUNT, 32'd2,  "ch3_count");
        chk(3, 1'b1, K_DATA,  32'h99, "ch3_back");
        chk(3, 1'b0, K_DATA,  32'h05, "ch3_front");
        chk(3, 1'b0, K_UDF,   32'h0,  "ch3_udf");

        // ch0: pop front then push back to 4 words
        cmd(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk(0, 1'b0, K_DATA,  32'h22, "ch0_popfront");
        cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk(0, 1'b0, K_COUNT, 32'd4,  "ch0_count4");
        chk(0, 1'b1, K_DATA,  32'h55, "ch0_back55");
        chk(0, 1'b0, K_EMPTY, 32'h2,  "pre_rst_empty");

        // Asynchronous reset between edges
        rst_n = 1'b0;
        chk(0, 1'b0, K_EMPTY, 32'hF,  "async_rst_empty");
        chk(0, 1'b0, K_FULL,  32'h0,  "async_rst_full");
        rst_n = 1'b1;
        chk(0, 1'b0, K_COUNT, 32'd0,  "post_rst_count");
        chk(0, 1'b0, K_DATA,  32'h0,  "post_rst_data");

        // First command after release
        cmd(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h66);
        chk(1, 1'b0, K_COUNT, 32'd1,  "first_cmd_count");
        chk(1, 1'b0, K_DATA,  32'h66, "first_cmd_data");

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending checks, expected 0", sb_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_deque.md
MULTI_DEQUE -- requirements
Module: multi_deque

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter CHANNELS, default 4, number of independent deques (>=2).
REQ-003 Parameter DEPTH, default 8, words per deque, power of two (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sel  input  max(1,$clog2(CHANNELS))  deque addressed by this cycle's command; values >= CHANNELS address nothing.
REQ-007 end_select  input  1  0 = front end, 1 = back end.
REQ-008 push  input  1  insert data_in at the selected end of the selected deque.
REQ-009 pop  input  1  remove the word at the selected end of the selected deque.
REQ-010 clear  input  1  empty the selected deque and clear its error flags.
REQ-011 data_in  input  WIDTH  word to insert.
REQ-012 data_out  output  WIDTH  combinational peek of the word at the selected end of the selected deque; 0 when that deque is empty or sel is out of range.
REQ-013 count  output  $clog2(DEPTH)+1  occupancy of the selected deque; 0 when sel is out of range.
REQ-014 empty  output  CHANNELS  bit i high when deque i holds 0 words.
REQ-015 full  output  CHANNELS  bit i high when deque i holds DEPTH words.
REQ-016 overflow  output  CHANNELS  bit i sticky: a push to full deque i was dropped.
REQ-017 underflow  output  CHANNELS  bit i sticky: a pop from empty deque i was dropped.

Function
REQ-018 Each deque SHALL be a circular buffer: head pointer (front word), tail pointer (next free slot after back), and count register; pointers wrap modulo DEPTH.
REQ-019 Only the deque addressed by sel SHALL change state in a cycle; all other deques hold.
REQ-020 Push front SHALL decrement head (with wrap), write data_in at the new head, and increment count.
REQ-021 Push back SHALL write data_in at tail, increment tail (with wrap), and increment count.
REQ-022 Pop front SHALL increment head; pop back SHALL decrement tail; both decrement count; storage contents are not required to be cleared.
REQ-023 Push and pop together on a non-empty deque SHALL overwrite the word at the selected end with data_in; pointers and count unchanged; no error flag set.
REQ-024 Push and pop together on an empty deque SHALL act as push alone; underflow not set.
REQ-025 Push alone on a full deque SHALL be dropped (state unchanged) and set its overflow bit.
REQ-026 Pop alone on an empty deque SHALL be dropped and set its underflow bit.
REQ-027 clear SHALL take priority over push and pop: head, tail, count of the selected deque go to 0 and its overflow/underflow bits clear on the next edge.
REQ-028 Commands SHALL take effect on the rising edge they are sampled at; data_out, count, empty, full reflect the new state in the following cycle (1-cycle latency), combinationally from registers thereafter.
REQ-029 Wrap-around SHALL be seamless: DEPTH alternating front/back pushes fill the deque regardless of starting pointer position.
REQ-030 Out-of-range sel SHALL make push/pop/clear no-ops with no error flags set.

Reset
REQ-031 While rst_n is low all heads, tails and counts SHALL be 0: empty all ones, full, overflow, underflow all zeros, data_out 0, count 0.
REQ-032 Reset asserted mid-operation SHALL discard all contents immediately, independent of clk; storage array need not be reset.
REQ-033 First command after rst_n deasserts SHALL be honoured on the first rising edge with rst_n high.

Verification
REQ-034 Push back 0x11, 0x22, 0x33 to ch0 -> count=3; peek front=0x11, back=0x33; empty[0]=0.
REQ-035 Push front 0xA1..0xA8 to ch2 (DEPTH=8) -> full[2]=1; ninth push -> dropped, overflow[2]=1; pop back 8 times yields 0xA1..0xA8 in order.
REQ-036 Pop empty ch1 -> underflow[1]=1, count=0; clear ch1 -> underflow[1]=0.
REQ-037 ch3 holds 0x05,0x06; push+pop back with 0x99 -> count=2, back=0x99, front=0x05.
REQ-038 Interleave pushes to ch0 and ch1 -> each deque holds only its own words; other channels stay empty.
REQ-039 Load ch0 with 4 words, drop rst_n between clock edges -> empty=all ones immediately; after release ch0 count=0, data_out=0.
